// File: rtl/gcm_tag_check.sv
// gcm_tag_check: receive-side GCM authentication.
//   Runs the AAD blocks, then the ciphertext blocks, then the length block
//   through a digit-serial GHASH multiply. It then XORs the result with
//   E(K,J0) and compares the TAG_BITS MSBs against the received tag.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_start               pulse; captures i_h/i_ek_j0/i_tag/i_len_* (ignored while busy)
//   i_h, i_ek_j0, i_tag   hash subkey, E(K,J0), received tag (MSB-aligned)
//   i_len_ad, i_len_ct    AAD / ciphertext lengths in bits
//   i_blk_valid/i_blk     block stream (AAD blocks first, then CT), o_blk_ready handshake
//   o_done                one-cycle result pulse
//   o_auth_ok, o_tag_calc result, held until the next i_start
//   busy                  high from the cycle after i_start through o_done
module gcm_tag_check #(
    parameter int RND_SIZE = 128,
    parameter int DIGIT    = 1,
    parameter int TAG_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [RND_SIZE-1:0] i_h,
    input  logic [RND_SIZE-1:0] i_ek_j0,
    input  logic [RND_SIZE-1:0] i_tag,
    input  logic [63:0]         i_len_ad,
    input  logic [63:0]         i_len_ct,
    input  logic                i_blk_valid,
    input  logic [RND_SIZE-1:0] i_blk,
    output logic                o_blk_ready,
    output logic                o_done,
    output logic                o_auth_ok,
    output logic [RND_SIZE-1:0] o_tag_calc,
    output logic                busy
);
    localparam int MUL_CYC = RND_SIZE / DIGIT;
    localparam int CW      = $clog2(MUL_CYC);
    // GHASH reduction constant in the reflected bit order (bit 127 is x^0)
    localparam logic [RND_SIZE-1:0] R_POLY = {8'he1, {(RND_SIZE-8){1'b0}}};
    // only the TAG_BITS MSBs take part in the comparison
    localparam logic [RND_SIZE-1:0] CMP_MASK = {RND_SIZE{1'b1}} << (RND_SIZE - TAG_BITS);

    typedef enum logic [2:0] {IDLE, LOAD, MULT, LENMUL, FINAL} state_t;

    state_t              state_q;
    logic [RND_SIZE-1:0] h_q, ekj0_q, tag_q;
    logic [63:0]         len_ad_q, len_ct_q;
    logic [57:0]         nad_q, nct_q;
    logic [RND_SIZE-1:0] s_q, x_q, z_q, v_q;
    logic [CW-1:0]       cnt_q;
    logic                done_q, ok_q;
    logic [RND_SIZE-1:0] tcalc_q;
    logic [RND_SIZE-1:0] z_d, v_d;
    logic                blk_rem;

    function automatic logic [57:0] nblocks(input logic [63:0] len);
        return {1'b0, len[63:7]} + 58'(|len[6:0]);
    endfunction

    // DIGIT multiplier bits per cycle, MSB of X first
    always_comb begin
        z_d = z_q;
        v_d = v_q;
        for (int i = 0; i < DIGIT; i++) begin
            if (x_q[RND_SIZE-1-i]) z_d = z_d ^ v_d;
            v_d = {1'b0, v_d[RND_SIZE-1:1]} ^ (v_d[0] ? R_POLY : '0);
        end
    end

    assign blk_rem     = (nad_q != '0) || (nct_q != '0);
    assign o_blk_ready = (state_q == LOAD) && blk_rem;
    assign o_done      = done_q;
    assign o_auth_ok   = ok_q;
    assign o_tag_calc  = tcalc_q;
    assign busy        = (state_q != IDLE) || done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            h_q      <= '0;
            ekj0_q   <= '0;
            tag_q    <= '0;
            len_ad_q <= '0;
            len_ct_q <= '0;
            nad_q    <= '0;
            nct_q    <= '0;
            s_q      <= '0;
            x_q      <= '0;
            z_q      <= '0;
            v_q      <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            tcalc_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        h_q      <= i_h;
                        ekj0_q   <= i_ek_j0;
                        tag_q    <= i_tag;
                        len_ad_q <= i_len_ad;
                        len_ct_q <= i_len_ct;
                        nad_q    <= nblocks(i_len_ad);
                        nct_q    <= nblocks(i_len_ct);
                        s_q      <= '0;
                        ok_q     <= 1'b0;
                        tcalc_q  <= '0;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    z_q   <= '0;
                    v_q   <= h_q;
                    cnt_q <= '0;
                    if (blk_rem) begin
                        if (i_blk_valid) begin
                            x_q <= s_q ^ i_blk;
                            // AAD blocks are consumed first, then ciphertext
                            if (nad_q != '0) nad_q <= nad_q - 58'd1;
                            else             nct_q <= nct_q - 58'd1;
                            state_q <= MULT;
                        end
                    end else begin
                        x_q     <= s_q ^ {len_ad_q, len_ct_q};
                        state_q <= LENMUL;
                    end
                end
                MULT, LENMUL: begin
                    z_q   <= z_d;
                    v_q   <= v_d;
                    x_q   <= x_q << DIGIT;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(MUL_CYC - 1)) begin
                        s_q     <= z_d;
                        state_q <= (state_q == MULT) ? LOAD : FINAL;
                    end
                end
                FINAL: begin
                    tcalc_q <= s_q ^ ekj0_q;
                    // full-width reduction every time: no data-dependent early exit
                    ok_q    <= ~|((s_q ^ ekj0_q ^ tag_q) & CMP_MASK);
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcm_tag_check.sv
module tb_gcm_tag_check;
    localparam logic [127:0] H1 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] EK1 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] C2 = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] T2 = 128'hab6e47d42cec13bdf53a67b21257bddf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start [3];
    logic [127:0] h, ekj0, tag, blk;
    logic [63:0]  la, lc;
    logic         bv;
    logic         rdy [3];
    logic         done [3];
    logic         ok [3];
    logic         bsy [3];
    logic [127:0] tc [3];

    int ncmp = 0;
    int nerr = 0;
    int digit_of [3] = '{1, 4, 8};
    int tbits_of [3] = '{128, 96, 128};

    logic [127:0] blks[$];
    logic [127:0] res_tag;
    logic         res_ok;
    int           res_cyc, res_hs, rdy_cnt;
    bit           rdy_drop;

    gcm_tag_check #(.DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(start[0]), .i_h(h), .i_ek_j0(ekj0), .i_tag(tag),
        .i_len_ad(la), .i_len_ct(lc), .i_blk_valid(bv), .i_blk(blk), .o_blk_ready(rdy[0]),
        .o_done(done[0]), .o_auth_ok(ok[0]), .o_tag_calc(tc[0]), .busy(bsy[0]));
    gcm_tag_check #(.DIGIT(4), .TAG_BITS(96)) dut4 (
        .clk(clk), .rst_n(rst_n), .i_start(start[1]), .i_h(h), .i_ek_j0(ekj0), .i_tag(tag),
        .i_len_ad(la), .i_len_ct(lc), .i_blk_valid(bv), .i_blk(blk), .o_blk_ready(rdy[1]),
        .o_done(done[1]), .o_auth_ok(ok[1]), .o_tag_calc(tc[1]), .busy(bsy[1]));
    gcm_tag_check #(.DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .i_start(start[2]), .i_h(h), .i_ek_j0(ekj0), .i_tag(tag),
        .i_len_ad(la), .i_len_ct(lc), .i_blk_valid(bv), .i_blk(blk), .o_blk_ready(rdy[2]),
        .o_done(done[2]), .o_auth_ok(ok[2]), .o_tag_calc(tc[2]), .busy(bsy[2]));

    task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    // GF(2^128) product, reflected bit order, one bit at a time
    function automatic logic [127:0] gfmul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z, v;
        z = '0;
        v = y;
        for (int i = 127; i >= 0; i--) begin
            if (x[i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
        end
        return z;
    endfunction

    function automatic logic [127:0] ref_tag();
        logic [127:0] s;
        s = '0;
        foreach (blks[i]) s = gfmul(s ^ blks[i], h);
        s = gfmul(s ^ {la, lc}, h);
        return s ^ ekj0;
    endfunction

    function automatic int ref_lat(input int d, input int nblk);
        return 1 + (nblk + 1) * (1 + 128 / digit_of[d]) + 1;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // append ceil(len/128) random blocks with the partial tail zero-padded
    task automatic add_blocks(input int len);
        logic [127:0] b, m;
        for (int i = 0; i < (len + 127) / 128; i++) begin
            b = rnd128();
            if (i == (len + 127) / 128 - 1 && (len % 128) != 0) begin
                m = ~128'h0;
                m = m << (128 - len % 128);
                b = b & m;
            end
            blks.push_back(b);
        end
    endtask

    // one transaction on DUT d; stall = cycles valid is held low once ready first rises,
    // glitch = cycle at which a spurious i_start is pulsed (-1 for none)
    task automatic run(input int d, input int stall, input int glitch);
        int  idx, stall_left, cyc;
        bit  hs;
        idx = 0; stall_left = stall; cyc = 0;
        res_hs = 0; rdy_cnt = 0; rdy_drop = 0;
        @(posedge clk); #1;
        start[d] = 1'b1;
        bv = 1'b0;
        while (1) begin
            hs = bv && rdy[d];
            @(posedge clk); #1;
            cyc++;
            start[d] = (cyc == glitch);
            if (cyc == glitch || cyc == glitch + 1) h = ~h;
            if (hs) begin idx++; res_hs++; end
            if (done[d]) break;
            if (cyc > 20000) begin
                ncmp++; nerr++;
                $error("FAIL timeout dut%0d: observed no o_done after %0d cycles", d, cyc);
                break;
            end
            if (rdy[d]) rdy_cnt++;
            if (stall_left > 0 && stall_left < stall && !rdy[d]) rdy_drop = 1;
            if (rdy[d] && stall_left > 0) begin
                stall_left--;
                bv = 1'b0;
            end else begin
                bv  = (idx < blks.size());
                blk = bv ? blks[idx] : rnd128();
            end
        end
        bv = 1'b0;
        res_tag = tc[d];
        res_ok  = ok[d];
        res_cyc = cyc;
        chk("busy_at_done", bsy[d], 1);
        @(posedge clk); #1;
        chk("done_pulse", {done[d], bsy[d]}, 0);
    endtask

    task automatic setup(input logic [127:0] th, input logic [127:0] tek, input logic [127:0] ttag,
                         input logic [63:0] tla, input logic [63:0] tlc);
        h = th; ekj0 = tek; tag = ttag; la = tla; lc = tlc;
        blks.delete();
    endtask

    initial begin
        logic [127:0] tref;
        int           d, nb;
        bit           seen;
        rst_n = 1'b0; bv = 1'b0; blk = '0;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        setup(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {rdy[0], done[0], ok[0], bsy[0], tc[0]}, 0);
        rst_n = 1'b1;

        // TC1, DIGIT=1
        setup(H1, EK1, EK1, 0, 0);
        run(0, 0, -1);
        chk("tc1_tag", res_tag, EK1);
        chk("tc1_ok", res_ok, 1);
        chk("tc1_lat", res_cyc, 131);
        chk("tc1_noready", rdy_cnt, 0);
        chk("tc1_hs", res_hs, 0);

        // TC2, DIGIT=1
        setup(H1, EK1, T2, 0, 128);
        blks.push_back(C2);
        run(0, 0, -1);
        chk("tc2_tag", res_tag, T2);
        chk("tc2_ok", res_ok, 1);
        chk("tc2_hs", res_hs, 1);
        chk("tc2_lat", res_cyc, 260);

        tag = T2 ^ 128'h1;
        run(0, 0, -1);
        chk("tc2_bad_ok", res_ok, 0);
        chk("tc2_bad_tag", res_tag, T2);

        // backpressure: valid withheld for 50 cycles in LOAD
        tag = T2;
        run(0, 50, -1);
        chk("bp_tag", res_tag, T2);
        chk("bp_ok", res_ok, 1);
        chk("bp_lat", res_cyc, 310);
        chk("bp_ready_held", rdy_drop, 0);
        chk("bp_ready_cycles", rdy_cnt, 51);

        // spurious start in the middle of MULT
        run(0, 0, 60);
        chk("glitch_tag", res_tag, T2);
        chk("glitch_ok", res_ok, 1);
        chk("glitch_lat", res_cyc, 260);

        // DIGIT=4 (TAG_BITS=96) and DIGIT=8
        setup(H1, EK1, EK1, 0, 0);
        run(1, 0, -1);
        chk("d4_tc1_tag", res_tag, EK1);
        chk("d4_tc1_lat", res_cyc, 35);
        run(2, 0, -1);
        chk("d8_tc1_tag", res_tag, EK1);
        chk("d8_tc1_lat", res_cyc, 19);
        setup(H1, EK1, T2, 0, 128);
        blks.push_back(C2);
        run(1, 0, -1);
        chk("d4_tc2_tag", res_tag, T2);
        chk("d4_tc2_ok", res_ok, 1);
        chk("d4_tc2_lat", res_cyc, 68);
        run(2, 0, -1);
        chk("d8_tc2_tag", res_tag, T2);
        chk("d8_tc2_lat", res_cyc, 36);

        // TAG_BITS=96: low 32 bits are don't-care, bit 32 is compared
        tag = T2 ^ 128'hdeadbeef;
        run(1, 0, -1);
        chk("t96_low_ok", res_ok, 1);
        chk("t96_low_tag", res_tag, T2);
        tag = T2 ^ (128'h1 << 32);
        run(1, 0, -1);
        chk("t96_bit32_ok", res_ok, 0);

        // reset in the middle of MULT
        setup(H1, EK1, EK1, 0, 0);
        @(posedge clk); #1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_busy", bsy[0], 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {rdy[0], done[0], ok[0], bsy[0], tc[0]}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (done[0] || bsy[0]) seen = 1;
        end
        chk("rst_no_done", seen, 0);
        run(0, 0, -1);
        chk("post_rst_tag", res_tag, EK1);
        chk("post_rst_ok", res_ok, 1);

        // randomized transactions against the reference model
        for (int t = 0; t < 9; t++) begin
            d = t % 3;
            setup(rnd128(), rnd128(), '0, 64'($urandom_range(0, 400)), 64'($urandom_range(0, 400)));
            add_blocks(int'(la));
            add_blocks(int'(lc));
            nb   = blks.size();
            tref = ref_tag();
            tag  = ($urandom_range(0, 1) == 1) ? tref : (tref ^ (128'h1 << $urandom_range(0, 127)));
            run(d, 0, -1);
            chk("rnd_tag", res_tag, tref);
            chk("rnd_ok", res_ok, (((tref ^ tag) >> (128 - tbits_of[d])) == 0) ? 1 : 0);
            chk("rnd_hs", res_hs, nb);
            chk("rnd_lat", res_cyc, ref_lat(d, nb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
